// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the multi-cycle sequencer: FSM states, opcode/ALU encodings, instruction field slices.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_BRANCH  = 2'd1,
    CLS_HALT    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  function automatic logic [3:0] f_op(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] ir);
    return ir[11:9];
  endfunction

  function automatic logic [2:0] f_rs0(input logic [15:0] ir);
    return ir[8:6];
  endfunction

  function automatic logic [2:0] f_rs1(input logic [15:0] ir);
    return ir[5:3];
  endfunction

  function automatic logic [15:0] f_imm(input logic [15:0] ir);
    return {{10{ir[5]}}, ir[5:0]};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/imem bundle; master is the sequencer, slave is the datapath + instruction memory side.
interface multicycle_ctrl_fsm_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  run;
  logic                  imem_req;
  logic [15:0]           imem_addr;
  logic                  imem_ack;
  logic [15:0]           imem_data;
  logic [REG_ADDR_W-1:0] rdAddr;
  logic [REG_ADDR_W-1:0] rs0Addr;
  logic [REG_ADDR_W-1:0] rs1Addr;
  logic [15:0]           immediate;
  logic                  ALUSrcA;
  logic                  ALUSrcB;
  logic [2:0]            ALUOp;
  logic [15:0]           ALUOut;
  logic                  writeEnable;
  logic [15:0]           dataWrite;
  logic [15:0]           PC;
  logic                  busy;
  logic                  halted;
  logic                  illegal;

  modport master (
    input  run, imem_ack, imem_data, ALUOut,
    output imem_req, imem_addr, rdAddr, rs0Addr, rs1Addr, immediate,
           ALUSrcA, ALUSrcB, ALUOp, writeEnable, dataWrite, PC, busy, halted, illegal
  );

  modport slave (
    output run, imem_ack, imem_data, ALUOut,
    input  imem_req, imem_addr, rdAddr, rs0Addr, rs1Addr, immediate,
           ALUSrcA, ALUSrcB, ALUOp, writeEnable, dataWrite, PC, busy, halted, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Combinational opcode decode: ALU operation, B-operand select and instruction class.
module multicycle_ctrl_fsm_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [2:0] alu_op_o,
  output logic       alu_src_b_o,
  output op_class_e  cls_o
);

  always_comb begin
    alu_op_o    = ALU_ADD;
    alu_src_b_o = 1'b0;
    cls_o       = CLS_ILLEGAL;
    case (op_i)
      OP_ADD:  begin alu_op_o = ALU_ADD; cls_o = CLS_ALU; end
      OP_SUB:  begin alu_op_o = ALU_SUB; cls_o = CLS_ALU; end
      OP_AND:  begin alu_op_o = ALU_AND; cls_o = CLS_ALU; end
      OP_OR:   begin alu_op_o = ALU_OR;  cls_o = CLS_ALU; end
      OP_ADDI: begin alu_op_o = ALU_ADD; alu_src_b_o = 1'b1; cls_o = CLS_ALU; end
      // Branch compares by subtraction; taken when the difference is zero.
      OP_BEQ:  begin alu_op_o = ALU_SUB; cls_o = CLS_BRANCH; end
      OP_HALT: cls_o = CLS_HALT;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer: fetch over req/ack (held until ack), then DECODE, EXEC and WB one cycle each.
// R/ADDI retire ack+3 cycles, BEQ ack+2; reset aborts immediately with no writeback.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          REG_ADDR_W = 3
) (
  input  logic                  CLK,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] result_q, result_d;
  logic        illegal_q, illegal_d;
  logic        alu_src_a_q, alu_src_a_d;

  logic [2:0]  dec_alu_op;
  logic        dec_alu_src_b;
  op_class_e   dec_cls;

  multicycle_ctrl_fsm_decode u_decode (
    .op_i        (f_op(ir_q)),
    .alu_op_o    (dec_alu_op),
    .alu_src_b_o (dec_alu_src_b),
    .cls_o       (dec_cls)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      alu_src_a_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      alu_src_a_q <= alu_src_a_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    alu_src_a_d = alu_src_a_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + 16'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_ALU, CLS_BRANCH: begin
            alu_src_a_d = 1'b1;
            state_d     = ST_EXEC;
          end
          CLS_HALT: state_d = ST_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_EXEC: begin
        result_d = bus.ALUOut;
        if (dec_cls == CLS_BRANCH) begin
          // pc_q already points past the branch, so the offset is relative to PC+1.
          if (bus.ALUOut == 16'h0000) pc_d = pc_q + f_imm(ir_q);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: state_d = ST_FETCH;
      ST_HALT: begin
        if (bus.run) begin
          illegal_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == ST_FETCH);
    bus.imem_addr   = pc_q;
    bus.PC          = pc_q;
    bus.rdAddr      = REG_ADDR_W'(f_rd(ir_q));
    bus.rs0Addr     = REG_ADDR_W'(f_rs0(ir_q));
    bus.rs1Addr     = REG_ADDR_W'(f_rs1(ir_q));
    // BEQ compares rd-field against rs0-field, so both sources shift up one field.
    if (dec_cls == CLS_BRANCH) begin
      bus.rs0Addr = REG_ADDR_W'(f_rd(ir_q));
      bus.rs1Addr = REG_ADDR_W'(f_rs0(ir_q));
    end
    bus.immediate   = f_imm(ir_q);
    bus.ALUSrcA     = alu_src_a_q;
    bus.ALUSrcB     = dec_alu_src_b;
    bus.ALUOp       = dec_alu_op;
    bus.writeEnable = (state_q == ST_WB);
    bus.dataWrite   = result_q;
    bus.busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    bus.halted      = (state_q == ST_HALT);
    bus.illegal     = illegal_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: datapath/imem fixture, directed table, corner sequences, random programs vs ISA model.
module tb_multicycle_ctrl_fsm;

  logic CLK;
  logic reset;

  multicycle_ctrl_fsm_if #(.REG_ADDR_W(3)) bus_if ();

  multicycle_ctrl_fsm #(.RESET_PC(16'h0000), .REG_ADDR_W(3)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- datapath fixture: regfile + A/B latches + ALU ----------------
  logic [15:0] preset_val [8];
  logic        dp_preset;
  logic [15:0] dp_rf [8];
  logic [15:0] dp_a, dp_b;
  logic [15:0] src_a, src_b;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (dp_preset) begin
      for (int i = 0; i < 8; i++) dp_rf[i] <= preset_val[i];
    end else if (bus_if.writeEnable) begin
      dp_rf[bus_if.rdAddr] <= bus_if.dataWrite;
    end
    dp_a <= dp_rf[bus_if.rs0Addr];
    dp_b <= dp_rf[bus_if.rs1Addr];
  end

  assign src_a         = bus_if.ALUSrcA ? dp_a : bus_if.PC;
  assign src_b         = bus_if.ALUSrcB ? bus_if.immediate : dp_b;
  assign bus_if.ALUOut = alu(bus_if.ALUOp, src_a, src_b);

  // ---------------- instruction memory and bookkeeping ----------------
  logic [15:0] imem [64];
  int          fixed_delay, cur_delay, ack_cnt;
  int          cyc, ack_cyc, wr_cyc;
  logic [15:0] fetch_q [$];
  logic [2:0]  wr_rd_q [$];
  logic [15:0] wr_dat_q [$];
  logic [15:0] exp_fetch_q [$];
  logic [2:0]  exp_rd_q [$];
  logic [15:0] exp_dat_q [$];
  logic        exp_illegal;
  int          n_checks, n_pass;

  function automatic logic [15:0] mem_rd(input logic [15:0] addr);
    return (addr < 16'd64) ? imem[addr[5:0]] : 16'hF000;
  endfunction

  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs0, input int rs1);
    return {op[3:0], rd[2:0], rs0[2:0], rs1[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rd, input int rs0, input logic [5:0] imm);
    return {op[3:0], rd[2:0], rs0[2:0], imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: imem responder acts just after the edge, monitor samples on the falling edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (bus_if.imem_ack) begin
      bus_if.imem_ack = 1'b0;
      ack_cnt = 0;
    end else if (bus_if.imem_req && !reset) begin
      if (ack_cnt >= cur_delay) begin
        bus_if.imem_ack  = 1'b1;
        bus_if.imem_data = mem_rd(bus_if.imem_addr);
        cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
    @(negedge CLK);
    cyc++;
    if (bus_if.imem_req && bus_if.imem_ack) begin
      fetch_q.push_back(bus_if.imem_addr);
      ack_cyc = cyc;
    end
    if (bus_if.writeEnable) begin
      wr_rd_q.push_back(bus_if.rdAddr);
      wr_dat_q.push_back(bus_if.dataWrite);
      wr_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dp_preset = 1'b1;
    bus_if.run = 1'b0;
    bus_if.imem_ack = 1'b0;
    ack_cnt = 0;
    cur_delay = (fixed_delay >= 0) ? fixed_delay : 0;
    step();
    step();
    reset = 1'b0;
    dp_preset = 1'b0;
    step();
    fetch_q.delete();
    wr_rd_q.delete();
    wr_dat_q.delete();
  endtask

  task automatic pulse_run();
    bus_if.run = 1'b1;
    step();
    bus_if.run = 1'b0;
  endtask

  task automatic wait_ack(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus_if.imem_req && bus_if.imem_ack) return;
      step();
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_until_halt(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus_if.halted) return;
      step();
    end
    chk("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 16'hF000;
  endtask

  task automatic fixed_preset();
    for (int i = 0; i < 8; i++) preset_val[i] = 16'h0000;
    preset_val[4] = 16'd5;
    preset_val[5] = 16'd2;
  endtask

  // Instruction-level reference: executes the program from PC 0 and lists fetches and writes.
  task automatic model_run();
    logic [15:0] rf [8];
    logic [15:0] pc, ins, imm, res;
    logic [3:0]  op;
    logic [2:0]  rd, rs0, rs1;
    exp_fetch_q.delete();
    exp_rd_q.delete();
    exp_dat_q.delete();
    exp_illegal = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = preset_val[i];
    pc = 16'h0000;
    for (int n = 0; n < 200; n++) begin
      ins = mem_rd(pc);
      exp_fetch_q.push_back(pc);
      pc  = pc + 16'd1;
      op  = ins[15:12];
      rd  = ins[11:9];
      rs0 = ins[8:6];
      rs1 = ins[5:3];
      imm = {{10{ins[5]}}, ins[5:0]};
      if (op == 4'hF) break;
      if (op > 4'h5) begin
        exp_illegal = 1'b1;
        break;
      end
      if (op == 4'h5) begin
        if (rf[rd] == rf[rs0]) pc = pc + imm;
      end else begin
        case (op)
          4'h0: res = rf[rs0] + rf[rs1];
          4'h1: res = rf[rs0] - rf[rs1];
          4'h2: res = rf[rs0] & rf[rs1];
          4'h3: res = rf[rs0] | rf[rs1];
          default: res = rf[rs0] + imm;
        endcase
        rf[rd] = res;
        exp_rd_q.push_back(rd);
        exp_dat_q.push_back(res);
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] instr;
    int          n_wr;
    logic [2:0]  rd;
    logic [15:0] dat;
    int          n_fetch;
    logic [15:0] next;
    logic        ill;
  } vec_t;

  vec_t vecs [11];

  initial begin
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    ack_cyc = 0;
    wr_cyc = 0;
    reset = 1'b1;
    dp_preset = 1'b0;
    bus_if.run = 1'b0;
    bus_if.imem_ack = 1'b0;
    bus_if.imem_data = 16'h0000;
    fixed_delay = 0;

    // Instruction sits at PC 5 (reached via BEQ r0,r0,+4 at PC 0); r4=5, r5=2.
    vecs[0]  = '{"add",      enc_r(0, 3, 4, 5),      1, 3'd3, 16'd7,    3, 16'd6, 1'b0};
    vecs[1]  = '{"sub",      enc_r(1, 2, 5, 4),      1, 3'd2, 16'hFFFD, 3, 16'd6, 1'b0};
    vecs[2]  = '{"and",      enc_r(2, 1, 4, 5),      1, 3'd1, 16'd0,    3, 16'd6, 1'b0};
    vecs[3]  = '{"or",       enc_r(3, 7, 4, 5),      1, 3'd7, 16'd7,    3, 16'd6, 1'b0};
    vecs[4]  = '{"addi_neg", enc_i(4, 1, 4, 6'h3F),  1, 3'd1, 16'd4,    3, 16'd6, 1'b0};
    vecs[5]  = '{"addi_pos", enc_i(4, 6, 5, 6'h1F),  1, 3'd6, 16'd33,   3, 16'd6, 1'b0};
    vecs[6]  = '{"add_r0",   enc_r(0, 0, 4, 4),      1, 3'd0, 16'd10,   3, 16'd6, 1'b0};
    vecs[7]  = '{"beq_take", enc_i(5, 4, 4, 6'h3E),  0, 3'd0, 16'd0,    3, 16'd4, 1'b0};
    vecs[8]  = '{"beq_not",  enc_i(5, 4, 5, 6'h3E),  0, 3'd0, 16'd0,    3, 16'd6, 1'b0};
    vecs[9]  = '{"illegal9", 16'h9000,               0, 3'd0, 16'd0,    2, 16'd0, 1'b1};
    vecs[10] = '{"halt",     16'hF000,               0, 3'd0, 16'd0,    2, 16'd0, 1'b0};

    // Reset state
    fixed_preset();
    clear_mem();
    #2;
    chk("rst_pc", bus_if.PC, 16'h0000);
    chk("rst_req", bus_if.imem_req, 1'b0);
    chk("rst_we", bus_if.writeEnable, 1'b0);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_halted", bus_if.halted, 1'b0);
    chk("rst_illegal", bus_if.illegal, 1'b0);
    do_reset();

    // Table-driven single instructions
    for (int v = 0; v < 11; v++) begin
      fixed_preset();
      clear_mem();
      imem[0] = enc_i(5, 0, 0, 6'd4);
      imem[5] = vecs[v].instr;
      fixed_delay = v % 3;
      do_reset();
      pulse_run();
      run_until_halt(200);
      chk({vecs[v].name, "_nfetch"}, fetch_q.size(), vecs[v].n_fetch);
      chk({vecs[v].name, "_nwr"}, wr_rd_q.size(), vecs[v].n_wr);
      chk({vecs[v].name, "_illegal"}, bus_if.illegal, vecs[v].ill);
      if (vecs[v].n_fetch == 3 && fetch_q.size() >= 3)
        chk({vecs[v].name, "_next_addr"}, fetch_q[2], vecs[v].next);
      if (vecs[v].n_wr == 1 && wr_rd_q.size() >= 1) begin
        chk({vecs[v].name, "_rd"}, wr_rd_q[0], vecs[v].rd);
        chk({vecs[v].name, "_data"}, wr_dat_q[0], vecs[v].dat);
      end
    end

    // ADD with a 3-cycle ack delay: request held, then WB exactly 3 cycles after ack
    begin
      int waits;
      fixed_preset();
      clear_mem();
      imem[0] = enc_r(0, 3, 4, 5);
      fixed_delay = 3;
      do_reset();
      pulse_run();
      waits = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus_if.imem_ack) break;
        chk("wait_req_held", bus_if.imem_req, 1'b1);
        chk("wait_addr_stable", bus_if.imem_addr, 16'h0000);
        waits++;
        step();
      end
      chk("wait_cycles", waits, 3);
      chk("ack_in_fetch", bus_if.imem_req, 1'b1);
      step();
      chk("dec_no_we", bus_if.writeEnable, 1'b0);
      chk("dec_no_req", bus_if.imem_req, 1'b0);
      chk("dec_rs0", bus_if.rs0Addr, 3'd4);
      chk("dec_rs1", bus_if.rs1Addr, 3'd5);
      step();
      chk("exec_srca", bus_if.ALUSrcA, 1'b1);
      chk("exec_srcb", bus_if.ALUSrcB, 1'b0);
      chk("exec_aluop", bus_if.ALUOp, 3'd0);
      chk("exec_no_we", bus_if.writeEnable, 1'b0);
      step();
      chk("wb_we", bus_if.writeEnable, 1'b1);
      chk("wb_rd", bus_if.rdAddr, 3'd3);
      chk("wb_data", bus_if.dataWrite, 16'd7);
      chk("wb_pc", bus_if.PC, 16'd1);
      chk("wb_latency", wr_cyc - ack_cyc, 3);
      step();
      chk("post_wb_we", bus_if.writeEnable, 1'b0);
      chk("post_wb_req", bus_if.imem_req, 1'b1);
      chk("post_wb_addr", bus_if.imem_addr, 16'd1);
    end

    // ADDI with negative immediate: B mux selects immediate, result wraps
    fixed_preset();
    clear_mem();
    imem[0] = enc_i(4, 1, 4, 6'h3F);
    fixed_delay = 0;
    do_reset();
    pulse_run();
    wait_ack(20);
    step();
    step();
    chk("addi_srcb", bus_if.ALUSrcB, 1'b1);
    chk("addi_imm", bus_if.immediate, 16'hFFFF);
    step();
    chk("addi_wb_data", bus_if.dataWrite, 16'd4);
    chk("addi_wb_rd", bus_if.rdAddr, 3'd1);

    // Reset during EXEC aborts without a write
    fixed_preset();
    clear_mem();
    imem[0] = enc_r(0, 3, 4, 5);
    fixed_delay = 1;
    do_reset();
    pulse_run();
    wait_ack(20);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("abort_busy", bus_if.busy, 1'b0);
    chk("abort_we", bus_if.writeEnable, 1'b0);
    chk("abort_pc", bus_if.PC, 16'h0000);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_no_write", wr_rd_q.size(), 0);
    chk("abort_idle", bus_if.busy, 1'b0);

    // Illegal opcode halts sticky, run restarts from the same PC
    fixed_preset();
    clear_mem();
    imem[0] = 16'h9000;
    fixed_delay = 0;
    do_reset();
    pulse_run();
    run_until_halt(50);
    chk("ill_halted", bus_if.halted, 1'b1);
    chk("ill_flag", bus_if.illegal, 1'b1);
    chk("ill_busy", bus_if.busy, 1'b0);
    chk("ill_pc", bus_if.PC, 16'd1);
    pulse_run();
    chk("rerun_halted", bus_if.halted, 1'b0);
    chk("rerun_illegal", bus_if.illegal, 1'b0);
    chk("rerun_busy", bus_if.busy, 1'b1);
    chk("rerun_addr", bus_if.imem_addr, 16'd1);

    // Backward branch from PC 0 wraps to 0xFFFF, then PC+1 wraps to 0
    fixed_preset();
    clear_mem();
    imem[0] = enc_i(5, 0, 0, 6'h3E);
    do_reset();
    pulse_run();
    run_until_halt(50);
    chk("wrap_nfetch", fetch_q.size(), 2);
    if (fetch_q.size() >= 2) chk("wrap_addr", fetch_q[1], 16'hFFFF);
    chk("wrap_pc", bus_if.PC, 16'h0000);

    // Randomized programs with random ack delays against the instruction-level model
    fixed_delay = -1;
    for (int p = 0; p < 20; p++) begin
      int sel;
      clear_mem();
      for (int i = 0; i < 8; i++)
        preset_val[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      for (int a = 0; a < 12; a++) begin
        sel = int'($urandom_range(0, 30));
        if (sel < 12)
          imem[a] = enc_r(sel % 4, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        else if (sel < 20)
          imem[a] = enc_i(4, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 6'($urandom));
        else if (sel < 30)
          imem[a] = enc_i(5, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 6'($urandom_range(0, 3)));
        else
          imem[a] = {4'($urandom_range(6, 14)), 12'($urandom)};
      end
      model_run();
      do_reset();
      pulse_run();
      run_until_halt(3000);
      chk("rnd_nfetch", fetch_q.size(), exp_fetch_q.size());
      chk("rnd_nwr", wr_rd_q.size(), exp_rd_q.size());
      chk("rnd_illegal", bus_if.illegal, exp_illegal);
      for (int i = 0; i < fetch_q.size() && i < exp_fetch_q.size(); i++)
        chk("rnd_fetch_addr", fetch_q[i], exp_fetch_q[i]);
      for (int i = 0; i < wr_rd_q.size() && i < exp_rd_q.size(); i++) begin
        chk("rnd_wr_rd", wr_rd_q[i], exp_rd_q[i]);
        chk("rnd_wr_data", wr_dat_q[i], exp_dat_q[i]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
